// File: rtl/hack_boot_loader.sv
// Hack CPU boot loader: receives a count header and program words over a byte link, writes them into ROM, then releases the CPU.
// Optional trailing 16-bit checksum check when HACK_BOOT_CHECKSUM_EN is defined.
module hack_boot_loader #(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic [15:0]       o_rom_wdata,
  output logic              o_rom_we,
  output logic              o_cpu_reset,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [3:0] {
    S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_RUN, S_ERR
`ifdef HACK_BOOT_CHECKSUM_EN
    , S_CHK_HI, S_CHK_LO
`endif
  } state_t;

  localparam logic [16:0] MAX_W17 = 17'(MAX_WORDS);

  state_t            r_state, w_state;
  logic [15:0]       r_count, w_count;
  logic [15:0]       r_idx,   w_idx;
  logic [7:0]        r_hold,  w_hold;
  logic [ADDR_W-1:0] r_rom_addr, w_rom_addr;
  logic [15:0]       r_rom_wdata, w_rom_wdata;
  logic              r_rx_ready, w_rx_ready;
  logic              r_rom_we, r_cpu_reset, r_busy, r_done, r_error;
  logic              w_xfer;
  logic [15:0]       w_idx_inc;
`ifdef HACK_BOOT_CHECKSUM_EN
  logic [15:0]       r_sum, w_sum;
`endif

  assign w_xfer    = i_rx_valid & r_rx_ready;
  assign w_idx_inc = r_idx + 16'd1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_HDR_HI;
    else            r_state <= w_state;
  end

  always_comb begin
    w_state     = r_state;
    w_count     = r_count;
    w_idx       = r_idx;
    w_hold      = r_hold;
    w_rom_addr  = r_rom_addr;
    w_rom_wdata = r_rom_wdata;
`ifdef HACK_BOOT_CHECKSUM_EN
    w_sum       = r_sum;
`endif
    case (r_state)
      S_HDR_HI: if (w_xfer) begin
        w_count = {i_rx_data, r_count[7:0]};
        w_state = S_HDR_LO;
      end
      S_HDR_LO: if (w_xfer) begin
        w_count = {r_count[15:8], i_rx_data};
        if (w_count == 16'd0 || {1'b0, w_count} > MAX_W17) w_state = S_ERR;
        else                                               w_state = S_DATA_HI;
      end
      S_DATA_HI: if (w_xfer) begin
        w_hold  = i_rx_data;
        w_state = S_DATA_LO;
      end
      // Address/data are latched here so they are already stable while WRITE drives rom_we.
      S_DATA_LO: if (w_xfer) begin
        w_rom_addr  = r_idx[ADDR_W-1:0];
        w_rom_wdata = {r_hold, i_rx_data};
        w_state     = S_WRITE;
      end
      S_WRITE: begin
        w_idx = w_idx_inc;
`ifdef HACK_BOOT_CHECKSUM_EN
        w_sum = r_sum + r_rom_wdata;
        w_state = (w_idx_inc == r_count) ? S_CHK_HI : S_DATA_HI;
`else
        w_state = (w_idx_inc == r_count) ? S_RUN : S_DATA_HI;
`endif
      end
`ifdef HACK_BOOT_CHECKSUM_EN
      S_CHK_HI: if (w_xfer) begin
        w_hold  = i_rx_data;
        w_state = S_CHK_LO;
      end
      S_CHK_LO: if (w_xfer) begin
        w_state = ({r_hold, i_rx_data} == r_sum) ? S_RUN : S_ERR;
      end
`endif
      S_RUN, S_ERR: if (i_start) begin
        w_state = S_HDR_HI;
        w_idx   = 16'd0;
        w_count = 16'd0;
`ifdef HACK_BOOT_CHECKSUM_EN
        w_sum   = 16'd0;
`endif
      end
      default: w_state = S_HDR_HI;
    endcase

    case (w_state)
      S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO: w_rx_ready = 1'b1;
`ifdef HACK_BOOT_CHECKSUM_EN
      S_CHK_HI, S_CHK_LO:                       w_rx_ready = 1'b1;
`endif
      default:                                  w_rx_ready = 1'b0;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count     <= 16'd0;
      r_idx       <= 16'd0;
      r_hold      <= 8'd0;
      r_rom_addr  <= '0;
      r_rom_wdata <= 16'd0;
      r_rx_ready  <= 1'b1;
      r_rom_we    <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef HACK_BOOT_CHECKSUM_EN
      r_sum       <= 16'd0;
`endif
    end else begin
      r_count     <= w_count;
      r_idx       <= w_idx;
      r_hold      <= w_hold;
      r_rom_addr  <= w_rom_addr;
      r_rom_wdata <= w_rom_wdata;
      r_rx_ready  <= w_rx_ready;
      r_rom_we    <= (w_state == S_WRITE);
      r_cpu_reset <= (w_state != S_RUN);
      r_busy      <= (w_state != S_RUN) && (w_state != S_ERR);
      r_done      <= (w_state == S_RUN);
      r_error     <= (w_state == S_ERR);
`ifdef HACK_BOOT_CHECKSUM_EN
      r_sum       <= w_sum;
`endif
    end
  end

  assign o_rx_ready  = r_rx_ready;
  assign o_rom_addr  = r_rom_addr;
  assign o_rom_wdata = r_rom_wdata;
  assign o_rom_we    = r_rom_we;
  assign o_cpu_reset = r_cpu_reset;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule
